// File: rtl/gpio_arbiter_pkg.sv
// Shared definitions for the two-requester GPIO register-port arbiter.
// No logic: arbiter FSM state encoding and GPIO register address map.
// Imported by gpio_arbiter and its bench.
package gpio_arbiter_pkg;

  // Arbiter FSM states; the encoding is visible on waveforms, so keep it fixed.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    DONE      = 2'd3
  } state_t;

  // GPIO register map; addresses 2 and 3 are passed through untouched.
  localparam logic [1:0] GPIO_ADDR_OUT = 2'b00;
  localparam logic [1:0] GPIO_ADDR_EN  = 2'b01;

endpackage

// File: rtl/gpio_arbiter_rr_arb2.sv
// Two-way round-robin picker: grants the sole requester, or on a tie the one not served last.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to sample gnt/valid.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  // Tie goes to whoever was not granted last; otherwise the single requester wins.
  always_comb begin
    valid = |req;
    if (req == 2'b11) begin
      gnt = ~last;
    end else begin
      gnt = req[1];
    end
  end

endmodule

// File: rtl/gpio_arbiter.sv
// Shares the GPIO register port between two requesters, round-robin, one access at a time.
// Latency: write strobe+ack the cycle after the grant edge; read ack read_wait edges after grant.
// Backpressure: requests are only sampled in IDLE; a requester holds req until its ack pulse.
module gpio_arbiter
  import gpio_arbiter_pkg::*;
#(
  parameter int npins     = 16,
  parameter int read_wait = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_req,
  input  logic             r0_we,
  input  logic [1:0]       r0_addr,
  input  logic [npins-1:0] r0_wdata,
  output logic             r0_ack,
  output logic [npins-1:0] r0_rdata,
  input  logic             r1_req,
  input  logic             r1_we,
  input  logic [1:0]       r1_addr,
  input  logic [npins-1:0] r1_wdata,
  output logic             r1_ack,
  output logic [npins-1:0] r1_rdata,
  output logic [npins-1:0] gpio_wdata,
  output logic [1:0]       gpio_addr,
  output logic             gpio_wstrobe,
  input  logic [npins-1:0] gpio_rdata,
  output logic             busy
);

  // Counter only needs to hold read_wait-1; keep at least one bit for read_wait = 1.
  localparam int CW = (read_wait > 1) ? $clog2(read_wait) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(read_wait - 1);

  state_t        state;
  logic          last;
  logic          gnt;
  logic [CW-1:0] cnt;

  logic             arb_gnt;
  logic             arb_vld;
  logic             sel_we;
  logic [1:0]       sel_addr;
  logic [npins-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req   ({r1_req, r0_req}),
    .last  (last),
    .gnt   (arb_gnt),
    .valid (arb_vld)
  );

  // Mux the winning requester's command fields.
  always_comb begin
    sel_we    = arb_gnt ? r1_we    : r0_we;
    sel_addr  = arb_gnt ? r1_addr  : r0_addr;
    sel_wdata = arb_gnt ? r1_wdata : r0_wdata;
  end

  assign busy = (state != IDLE);

  // Access FSM; strobe, acks and read data are all registered on state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last         <= 1'b1;
      gnt          <= 1'b0;
      cnt          <= '0;
      r0_ack       <= 1'b0;
      r1_ack       <= 1'b0;
      gpio_wstrobe <= 1'b0;
      gpio_wdata   <= '0;
      gpio_addr    <= '0;
      r0_rdata     <= '0;
      r1_rdata     <= '0;
    end else begin
      r0_ack       <= 1'b0;
      r1_ack       <= 1'b0;
      gpio_wstrobe <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_vld) begin
            gnt        <= arb_gnt;
            last       <= arb_gnt;
            gpio_addr  <= sel_addr;
            gpio_wdata <= sel_wdata;
            if (sel_we) begin
              state        <= WRITE;
              gpio_wstrobe <= 1'b1;
              r0_ack       <= ~arb_gnt;
              r1_ack       <= arb_gnt;
            end else begin
              state <= READ_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        READ_WAIT: begin
          if (cnt == '0) begin
            state <= DONE;
            if (gnt) begin
              r1_rdata <= gpio_rdata;
              r1_ack   <= 1'b1;
            end else begin
              r0_rdata <= gpio_rdata;
              r0_ack   <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_arbiter.sv
// Self-checking bench for gpio_arbiter: directed scenarios plus random traffic.
// The reference model tracks each access as a time window (grant edge, ack edge).
// Outputs are compared every cycle on the falling edge.
module tb_gpio_arbiter;
  import gpio_arbiter_pkg::*;

  localparam int NP = 16;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [1:0]    r0_addr, r1_addr;
  logic [NP-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata;
  logic          r0_ack, r1_ack;
  logic [NP-1:0] gpio_wdata, gpio_rdata;
  logic [1:0]    gpio_addr;
  logic          gpio_wstrobe, busy;

  always #5 clk = ~clk;

  gpio_arbiter #(.npins(NP), .read_wait(RW)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .gpio_wdata(gpio_wdata), .gpio_addr(gpio_addr), .gpio_wstrobe(gpio_wstrobe),
    .gpio_rdata(gpio_rdata), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  // Reference model: one access window at a time.
  bit            m_active, m_who, m_we, m_last;
  int            m_g, m_a, m_next_free;
  logic [1:0]    m_gaddr;
  logic [NP-1:0] m_gwdata;
  logic [NP-1:0] m_rdata [2];
  bit            m_ack [2];
  bit            m_busy, m_strobe;

  // Requester drivers.
  bit            pend [2], hold [2], auto_mode [2];
  logic          we_d [2];
  logic [1:0]    addr_d [2];
  logic [NP-1:0] wd_d [2];
  bit            use_fixed;
  logic [NP-1:0] rd_fixed;

  // Monitors.
  int            strobe_cnt, busy_cnt, last_ack_edge;
  logic [1:0]    last_strobe_addr;
  logic [NP-1:0] last_strobe_wdata;
  int            ack_log [$];

  task automatic chk(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_last = 1; m_next_free = 0;
    m_gaddr = '0; m_gwdata = '0;
    m_rdata[0] = '0; m_rdata[1] = '0;
    m_ack[0] = 0; m_ack[1] = 0;
    m_busy = 0; m_strobe = 0;
  endtask

  task automatic apply_inputs();
    r0_req = pend[0]; r0_we = we_d[0]; r0_addr = addr_d[0]; r0_wdata = wd_d[0];
    r1_req = pend[1]; r1_we = we_d[1]; r1_addr = addr_d[1]; r1_wdata = wd_d[1];
    gpio_rdata = use_fixed ? rd_fixed : NP'($urandom);
  endtask

  task automatic req_op(input int i, input logic we, input logic [1:0] addr, input logic [NP-1:0] wd);
    pend[i] = 1; we_d[i] = we; addr_d[i] = addr; wd_d[i] = wd;
    apply_inputs();
  endtask

  task automatic new_op(input int i);
    pend[i] = 1;
    we_d[i] = 1'($urandom_range(0, 1));
    addr_d[i] = 2'($urandom_range(0, 3));
    wd_d[i] = NP'($urandom);
  endtask

  // Model one rising edge n given the inputs the DUT sampled there.
  task automatic model_edge(input int n, input bit s_req [2], input bit s_we [2],
                            input logic [1:0] s_addr [2], input logic [NP-1:0] s_wd [2],
                            input logic [NP-1:0] s_rd);
    bit who;
    m_ack[0] = 0; m_ack[1] = 0; m_strobe = 0;
    if (m_active && n > m_a) m_active = 0;
    if (!m_active && n >= m_next_free && (s_req[0] || s_req[1])) begin
      who = (s_req[0] && s_req[1]) ? !m_last : s_req[1];
      m_active = 1; m_who = who; m_we = s_we[who]; m_g = n;
      m_a = n + (m_we ? 0 : RW);
      m_next_free = m_a + 2;
      m_gaddr = s_addr[who]; m_gwdata = s_wd[who]; m_last = who;
    end
    if (m_active && n == m_a) begin
      m_ack[m_who] = 1;
      m_strobe = m_we;
      if (!m_we) m_rdata[m_who] = s_rd;
    end
    m_busy = m_active;
  endtask

  // One clock: model the rising edge, compare on the falling edge, then drive.
  task automatic step();
    bit s_req [2], s_we [2];
    logic [1:0] s_addr [2];
    logic [NP-1:0] s_wd [2];
    logic [NP-1:0] s_rd;
    bit s_rst;
    s_req[0] = r0_req; s_we[0] = r0_we; s_addr[0] = r0_addr; s_wd[0] = r0_wdata;
    s_req[1] = r1_req; s_we[1] = r1_we; s_addr[1] = r1_addr; s_wd[1] = r1_wdata;
    s_rd = gpio_rdata; s_rst = reset;
    @(posedge clk);
    edge_n++;
    if (s_rst || reset) model_reset();
    else model_edge(edge_n, s_req, s_we, s_addr, s_wd, s_rd);
    @(negedge clk);
    chk("busy", busy, m_busy);
    chk("r0_ack", r0_ack, m_ack[0]);
    chk("r1_ack", r1_ack, m_ack[1]);
    chk("gpio_wstrobe", gpio_wstrobe, m_strobe);
    chk("gpio_addr", gpio_addr, m_gaddr);
    chk("gpio_wdata", gpio_wdata, m_gwdata);
    chk("r0_rdata", r0_rdata, m_rdata[0]);
    chk("r1_rdata", r1_rdata, m_rdata[1]);
    chk("dual_ack", r0_ack & r1_ack, 0);
    if (gpio_wstrobe) begin
      strobe_cnt++; last_strobe_addr = gpio_addr; last_strobe_wdata = gpio_wdata;
    end
    if (busy) busy_cnt++;
    if (r0_ack) begin ack_log.push_back(0); last_ack_edge = edge_n; end
    if (r1_ack) begin ack_log.push_back(1); last_ack_edge = edge_n; end
    for (int i = 0; i < 2; i++) begin
      if (m_ack[i]) begin
        pend[i] = 0;
        if (hold[i]) new_op(i);
      end else if (!pend[i] && auto_mode[i] && $urandom_range(0, 3) == 0) begin
        new_op(i);
      end
    end
    apply_inputs();
  endtask

  task automatic clear_drivers();
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; hold[i] = 0; auto_mode[i] = 0;
      we_d[i] = 0; addr_d[i] = '0; wd_d[i] = '0;
    end
  endtask

  initial begin
    int t0, n0, k;
    bit r1_seen;
    clear_drivers();
    use_fixed = 0; rd_fixed = '0;
    strobe_cnt = 0; busy_cnt = 0; last_ack_edge = 0;
    last_strobe_addr = '0; last_strobe_wdata = '0;
    model_reset();
    apply_inputs();

    // Reset state, held for two cycles.
    repeat (2) step();
    reset = 1'b0;
    step();

    // Single write to the enable register.
    strobe_cnt = 0; busy_cnt = 0; ack_log.delete();
    req_op(0, 1'b1, GPIO_ADDR_EN, 16'h00FF);
    repeat (5) step();
    chk("wr_strobes", 16'(strobe_cnt), 16'd1);
    chk("wr_busy_cycles", 16'(busy_cnt), 16'd1);
    chk("wr_ack_count", 16'(ack_log.size()), 16'd1);
    chk("wr_strobe_addr", 16'(last_strobe_addr), 16'(GPIO_ADDR_EN));
    chk("wr_strobe_wdata", last_strobe_wdata, 16'h00FF);

    // Single read by requester 1; ack arrives read_wait edges after the sampling edge.
    use_fixed = 1; rd_fixed = 16'hA5C3;
    strobe_cnt = 0; ack_log.delete();
    req_op(1, 1'b0, GPIO_ADDR_OUT, '0);
    t0 = edge_n + 1;
    repeat (6) step();
    chk("rd_latency", 16'(last_ack_edge - t0), 16'(RW));
    chk("rd_r1_rdata", r1_rdata, 16'hA5C3);
    chk("rd_r0_rdata_untouched", r0_rdata, 16'h0000);
    chk("rd_no_strobe", 16'(strobe_cnt), 16'd0);
    use_fixed = 0;

    // Contention from reset: both requesters held back-to-back.
    reset = 1'b1; clear_drivers(); apply_inputs();
    step();
    ack_log.delete();
    hold[0] = 1; hold[1] = 1; new_op(0); new_op(1); apply_inputs();
    reset = 1'b0;
    for (int c = 0; c < 60 && ack_log.size() < 4; c++) step();
    hold[0] = 0; hold[1] = 0;
    chk("contention_acks", 16'(ack_log.size() >= 4), 16'd1);
    for (int j = 0; j < 4; j++) begin
      k = (j < ack_log.size()) ? ack_log[j] : 7;
      chk("contention_order", 16'(k), 16'(j % 2));
    end
    repeat (12) step();

    // Starvation: r0 streams continuously, r1 asks once and must be next.
    hold[0] = 1; new_op(0); apply_inputs();
    repeat (5) step();
    ack_log.delete();
    req_op(1, 1'b1, 2'd2, 16'hBEEF);
    r1_seen = 0; n0 = 0;
    for (int c = 0; c < 30 && !r1_seen; c++) begin
      step();
      while (ack_log.size() > 0) begin
        k = ack_log.pop_front();
        if (k == 1) r1_seen = 1;
        else if (!r1_seen) n0++;
      end
    end
    chk("starve_r1_served", 16'(r1_seen), 16'd1);
    chk("starve_r0_first_at_most_once", 16'(n0 <= 1), 16'd1);
    hold[0] = 0;
    repeat (12) step();

    // Reset in the middle of a read wait.
    req_op(0, 1'b0, 2'd1, '0);
    repeat (2) step();
    chk("midrd_busy_before", busy, 1'b1);
    ack_log.delete();
    reset = 1'b1; clear_drivers(); apply_inputs();
    #1;
    chk("midrd_busy", busy, 1'b0);
    chk("midrd_strobe", gpio_wstrobe, 1'b0);
    chk("midrd_addr", 16'(gpio_addr), 16'd0);
    chk("midrd_wdata", gpio_wdata, 16'd0);
    chk("midrd_rdata0", r0_rdata, 16'd0);
    chk("midrd_rdata1", r1_rdata, 16'd0);
    repeat (2) step();
    chk("midrd_no_ack", 16'(ack_log.size()), 16'd0);
    reset = 1'b0;
    req_op(0, 1'b0, GPIO_ADDR_OUT, '0);
    t0 = edge_n + 1;
    repeat (6) step();
    chk("postrst_rd_latency", 16'(last_ack_edge - t0), 16'(RW));

    // Write to a reserved address is passed through.
    strobe_cnt = 0; ack_log.delete();
    req_op(0, 1'b1, 2'd3, 16'h1234);
    repeat (4) step();
    chk("rsv_strobes", 16'(strobe_cnt), 16'd1);
    chk("rsv_addr", 16'(last_strobe_addr), 16'd3);
    chk("rsv_wdata", last_strobe_wdata, 16'h1234);
    chk("rsv_ack", 16'(ack_log.size()), 16'd1);

    // Random traffic from both requesters.
    auto_mode[0] = 1; auto_mode[1] = 1;
    repeat (400) step();
    auto_mode[0] = 0; auto_mode[1] = 0;
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
